// File: rtl/msg_sender_pkg.sv
// Shared types and constants for the message sender.
package msg_sender_pkg;

    localparam int HEADER_LEN = 8;
    localparam int SEQ_W      = 16;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SETTLE,
        HDR_LOAD,
        HDR_GAP,
        DAT_LOAD,
        DAT_GAP,
        DONE
    } state_t;

    // Messages no longer than the header carry no data bytes.
    function automatic logic [15:0] dataBytesOf(input logic [15:0] msgByteCount);
        return (msgByteCount > 16'(HEADER_LEN)) ? (msgByteCount - 16'(HEADER_LEN)) : 16'd0;
    endfunction

endpackage

// File: rtl/msg_sender_if.sv
// Bundle between msg_sender and its header generator, data memory and byte transmitter.
interface msg_sender_if;
    import msg_sender_pkg::*;

    logic             Send;
    logic             Busy;
    logic             Done;
    logic [SEQ_W-1:0] SequenceNumber;
    logic [15:0]      MsgByteCount;
    logic             HdrClearAddr;
    logic             HdrNextAddr;
    logic [7:0]       HdrByte;
    logic             HdrLast;
    logic             DataClearAddr;
    logic             DataNextAddr;
    logic [7:0]       DataByte;
    logic [7:0]       TxByte;
    logic             TxLoad;
    logic             TxReady;

    modport master (
        input  Send, MsgByteCount, HdrByte, HdrLast, DataByte, TxReady,
        output Busy, Done, SequenceNumber, HdrClearAddr, HdrNextAddr,
               DataClearAddr, DataNextAddr, TxByte, TxLoad
    );

    modport slave (
        output Send, MsgByteCount, HdrByte, HdrLast, DataByte, TxReady,
        input  Busy, Done, SequenceNumber, HdrClearAddr, HdrNextAddr,
               DataClearAddr, DataNextAddr, TxByte, TxLoad
    );

endinterface

// File: rtl/msg_sender_tx_byte_handshake.sv
// Hands one byte to the transmitter when a load is requested and TxReady is high.
// Latency: TxLoad/TxByte registered, visible the cycle after acceptance.
// Backpressure: request simply waits while TxReady is low; accepted flags the handoff.
module tx_byte_handshake (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       loadReq,
    input  logic [7:0] loadByte,
    input  logic       TxReady,
    output logic       accepted,
    output logic       TxLoad,
    output logic [7:0] TxByte
);

    assign accepted = loadReq & TxReady;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            TxLoad <= 1'b0;
            TxByte <= 8'h00;
        end else begin
            TxLoad <= accepted;
            if (accepted) begin
                TxByte <= loadByte;
            end
        end
    end

endmodule

// File: rtl/msg_sender.sv
// Sequences one message: clear addresses, stream 8 header bytes then data bytes to the TX.
// Latency: first TxLoad 4 cycles after Send, then one byte per 2 cycles; Done 1 cycle after last byte.
// Backpressure: each byte waits in its LOAD state until TxReady; Send ignored while Busy.
module msg_sender
    import msg_sender_pkg::*;
(
    input  logic         Clk,
    input  logic         Reset,
    msg_sender_if.master bus
);

    state_t           state;
    logic [15:0]      dataRemaining;
    logic [SEQ_W-1:0] seqNum;
    logic             busy;
    logic             done;
    logic             hdrClear;
    logic             hdrNext;
    logic             dataClear;
    logic             dataNext;

    logic             loadReq;
    logic [7:0]       loadByte;
    logic             accepted;
    logic             txLoad;
    logic [7:0]       txByte;

    assign loadReq  = (state == HDR_LOAD) || (state == DAT_LOAD);
    assign loadByte = (state == DAT_LOAD) ? bus.DataByte : bus.HdrByte;

    tx_byte_handshake u_tx (
        .Clk      (Clk),
        .Reset    (Reset),
        .loadReq  (loadReq),
        .loadByte (loadByte),
        .TxReady  (bus.TxReady),
        .accepted (accepted),
        .TxLoad   (txLoad),
        .TxByte   (txByte)
    );

    assign bus.TxLoad         = txLoad;
    assign bus.TxByte         = txByte;
    assign bus.Busy           = busy;
    assign bus.Done           = done;
    assign bus.SequenceNumber = seqNum;
    assign bus.HdrClearAddr   = hdrClear;
    assign bus.HdrNextAddr    = hdrNext;
    assign bus.DataClearAddr  = dataClear;
    assign bus.DataNextAddr   = dataNext;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state         <= IDLE;
            dataRemaining <= 16'd0;
            seqNum        <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            hdrClear      <= 1'b0;
            hdrNext       <= 1'b0;
            dataClear     <= 1'b0;
            dataNext      <= 1'b0;
        end else begin
            done      <= 1'b0;
            hdrClear  <= 1'b0;
            hdrNext   <= 1'b0;
            dataClear <= 1'b0;
            dataNext  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.Send) begin
                        busy      <= 1'b1;
                        hdrClear  <= 1'b1;
                        dataClear <= 1'b1;
                        state     <= CLEAR;
                    end
                end
                CLEAR: begin
                    dataRemaining <= dataBytesOf(bus.MsgByteCount);
                    state         <= SETTLE;
                end
                SETTLE: state <= HDR_LOAD;
                HDR_LOAD: begin
                    // The final header address is not advanced past.
                    if (accepted) begin
                        if (!bus.HdrLast) begin
                            hdrNext <= 1'b1;
                            state   <= HDR_GAP;
                        end else if (dataRemaining == 16'd0) begin
                            state <= DONE;
                        end else begin
                            state <= DAT_GAP;
                        end
                    end
                end
                HDR_GAP: state <= HDR_LOAD;
                DAT_LOAD: begin
                    if (accepted) begin
                        dataRemaining <= dataRemaining - 16'd1;
                        if (dataRemaining != 16'd1) begin
                            dataNext <= 1'b1;
                            state    <= DAT_GAP;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                DAT_GAP: state <= DAT_LOAD;
                DONE: begin
                    done   <= 1'b1;
                    busy   <= 1'b0;
                    seqNum <= seqNum + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_msg_sender.sv
// Bench for msg_sender: models header generator and data memory, scoreboards the TX byte stream.
module tb_msg_sender;
    import msg_sender_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    msg_sender_if bus();
    msg_sender dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] expQ[$];
    logic [7:0] obsQ[$];
    int txCnt = 0, hdrNextCnt = 0, dataNextCnt = 0, doneCnt = 0, orphanNext = 0;
    int readyDelay = 0, rdyWait = 0;
    logic [15:0] expSeq = 16'h0000;

    // Header: magic 0x1234, total length, sequence number (all little endian), two pad bytes.
    function automatic logic [7:0] hdrByteOf(input logic [2:0] a, input logic [15:0] cnt, input logic [15:0] seq);
        case (a)
            3'd0:    return 8'h34;
            3'd1:    return 8'h12;
            3'd2:    return cnt[7:0];
            3'd3:    return cnt[15:8];
            3'd4:    return seq[7:0];
            3'd5:    return seq[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] dataRom(input logic [7:0] a);
        case (a)
            8'd0:    return 8'hAA;
            8'd1:    return 8'hBB;
            8'd2:    return 8'hCC;
            8'd3:    return 8'hDD;
            default: return 8'h50 + a;
        endcase
    endfunction

    logic [2:0]  hdrAddr  = 3'd0;
    logic [15:0] hdrSeq   = 16'h0;
    logic [15:0] hdrCnt   = 16'h0;
    logic [7:0]  dataAddr = 8'd0;

    always @(posedge Clk) begin
        if (bus.HdrClearAddr) begin
            hdrAddr <= 3'd0;
            hdrSeq  <= bus.SequenceNumber;
            hdrCnt  <= bus.MsgByteCount;
        end else if (bus.HdrNextAddr) begin
            hdrAddr <= hdrAddr + 3'd1;
        end
        if (bus.DataClearAddr) dataAddr <= 8'd0;
        else if (bus.DataNextAddr) dataAddr <= dataAddr + 8'd1;
    end

    assign bus.HdrByte  = hdrByteOf(hdrAddr, hdrCnt, hdrSeq);
    assign bus.HdrLast  = (hdrAddr == 3'd7);
    assign bus.DataByte = dataRom(dataAddr);

    task automatic push_msg(input logic [15:0] cnt, input logic [15:0] seq);
        for (int i = 0; i < HEADER_LEN; i++) expQ.push_back(hdrByteOf(3'(i), cnt, seq));
        for (int j = 0; j < int'(cnt) - HEADER_LEN; j++) expQ.push_back(dataRom(8'(j)));
    endtask

    // Advance to the next falling edge, record what the DUT did, then play the transmitter.
    task automatic tick();
        @(negedge Clk);
        if (bus.TxLoad) begin
            obsQ.push_back(bus.TxByte);
            txCnt++;
        end
        if (bus.HdrNextAddr) hdrNextCnt++;
        if (bus.DataNextAddr) dataNextCnt++;
        if ((bus.HdrNextAddr || bus.DataNextAddr) && !bus.TxLoad) orphanNext++;
        if (bus.Done) doneCnt++;
        if (bus.TxLoad || bus.HdrClearAddr) rdyWait = readyDelay;
        else if (rdyWait > 0) rdyWait--;
        bus.TxReady = (rdyWait == 0);
    endtask

    // Tick n observes the cycle n after the edge that samples Send.
    task automatic run_msg(input logic [15:0] cnt, output logic clr, output int firstLoad, output int doneAt);
        clr = 1'b0; firstLoad = 0; doneAt = 0;
        bus.MsgByteCount = cnt;
        bus.Send = 1'b1;
        for (int n = 1; n <= 400 && doneAt == 0; n++) begin
            tick();
            if (n == 1) begin
                clr = bus.Busy && bus.HdrClearAddr && bus.DataClearAddr;
                bus.Send = 1'b0;
            end
            if (firstLoad == 0 && bus.TxLoad) firstLoad = n;
            if (bus.Done) doneAt = n;
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (3) tick();
        Reset = 1'b0;
        tick();
        vectors++;
        if ({bus.Busy, bus.Done, bus.TxLoad, bus.HdrClearAddr, bus.HdrNextAddr, bus.DataClearAddr, bus.DataNextAddr} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b, want 0000000", {bus.Busy, bus.Done, bus.TxLoad, bus.HdrClearAddr, bus.HdrNextAddr, bus.DataClearAddr, bus.DataNextAddr});
        end
        vectors++;
        if (bus.TxByte !== 8'h00) begin miscompares++; $display("FAIL reset_txbyte: got %02h, want 00", bus.TxByte); end
        vectors++;
        if (bus.SequenceNumber !== 16'h0000) begin miscompares++; $display("FAIL reset_seq: got %04h, want 0000", bus.SequenceNumber); end
        vectors++;
        if (dut.state !== IDLE) begin miscompares++; $display("FAIL reset_state: got %0d, want IDLE", dut.state); end
    endtask

    task automatic test_header_only();
        logic [15:0] cnts [2];
        logic cl;
        int fl, da, x0, h0, d0;
        logic [7:0] e, o;
        cnts[0] = 16'd8;
        cnts[1] = 16'd5;
        for (int t = 0; t < 2; t++) begin
            x0 = txCnt; h0 = hdrNextCnt; d0 = dataNextCnt;
            push_msg(cnts[t], expSeq);
            run_msg(cnts[t], cl, fl, da);
            expSeq++;
            vectors++;
            if (cl !== 1'b1) begin miscompares++; $display("FAIL hdr_only_clear cnt=%0d: Busy&clears got %b, want 1", cnts[t], cl); end
            vectors++;
            if (fl != 4) begin miscompares++; $display("FAIL hdr_only_first_load cnt=%0d: got cycle %0d, want 4", cnts[t], fl); end
            vectors++;
            if (da != 19) begin miscompares++; $display("FAIL hdr_only_done_cycle cnt=%0d: got %0d, want 19", cnts[t], da); end
            vectors++;
            if (txCnt - x0 != 8 || hdrNextCnt - h0 != 7 || dataNextCnt - d0 != 0) begin
                miscompares++;
                $display("FAIL hdr_only_pulses cnt=%0d: got tx=%0d hnext=%0d dnext=%0d, want 8/7/0", cnts[t], txCnt - x0, hdrNextCnt - h0, dataNextCnt - d0);
            end
            while (expQ.size() > 0 && obsQ.size() > 0) begin
                e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
                if (o !== e) begin miscompares++; $display("FAIL hdr_only_byte cnt=%0d: got %02h, want %02h", cnts[t], o, e); end
            end
            expQ.delete(); obsQ.delete();
            vectors++;
            if (bus.SequenceNumber !== expSeq) begin miscompares++; $display("FAIL hdr_only_seq: got %04h, want %04h", bus.SequenceNumber, expSeq); end
        end
    endtask

    task automatic test_data_stream();
        logic cl;
        int fl, da, x0, h0, d0;
        logic [7:0] e, o;
        x0 = txCnt; h0 = hdrNextCnt; d0 = dataNextCnt;
        push_msg(16'd12, expSeq);
        run_msg(16'd12, cl, fl, da);
        expSeq++;
        vectors++;
        if (da != 27) begin miscompares++; $display("FAIL data_done_cycle: got %0d, want 27", da); end
        vectors++;
        if (txCnt - x0 != 12 || hdrNextCnt - h0 != 7 || dataNextCnt - d0 != 3) begin
            miscompares++;
            $display("FAIL data_pulses: got tx=%0d hnext=%0d dnext=%0d, want 12/7/3", txCnt - x0, hdrNextCnt - h0, dataNextCnt - d0);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL data_byte: got %02h, want %02h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        vectors++;
        if (bus.SequenceNumber !== expSeq) begin miscompares++; $display("FAIL data_seq: got %04h, want %04h", bus.SequenceNumber, expSeq); end
    endtask

    task automatic test_backpressure();
        logic cl;
        int fl, da, x0, h0, d0, or0;
        logic [7:0] e, o;
        readyDelay = 5;
        x0 = txCnt; h0 = hdrNextCnt; d0 = dataNextCnt; or0 = orphanNext;
        push_msg(16'd11, expSeq);
        run_msg(16'd11, cl, fl, da);
        expSeq++;
        vectors++;
        if (da == 0) begin miscompares++; $display("FAIL bp_timeout: Done got 0, want 1 within 400 cycles"); end
        vectors++;
        if (txCnt - x0 != 11 || hdrNextCnt - h0 != 7 || dataNextCnt - d0 != 2 || orphanNext != or0) begin
            miscompares++;
            $display("FAIL bp_pulses: got tx=%0d hnext=%0d dnext=%0d stray=%0d, want 11/7/2/0", txCnt - x0, hdrNextCnt - h0, dataNextCnt - d0, orphanNext - or0);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL bp_byte: got %02h, want %02h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        readyDelay = 0; rdyWait = 0; bus.TxReady = 1'b1;
    endtask

    task automatic test_reset_mid_message();
        logic cl;
        int fl, da, x0;
        logic hit;
        logic [7:0] e, o;
        x0 = txCnt; hit = 1'b0;
        bus.MsgByteCount = 16'd12;
        bus.Send = 1'b1;
        for (int n = 1; n <= 200 && !hit; n++) begin
            tick();
            bus.Send = 1'b0;
            if (txCnt - x0 == 11) hit = 1'b1;
        end
        vectors++;
        if (!hit) begin miscompares++; $display("FAIL rst_mid_reach: 3rd data byte got %0d bytes, want 11", txCnt - x0); end
        Reset = 1'b1;
        tick();
        vectors++;
        if ({bus.Busy, bus.Done, bus.TxLoad, bus.HdrClearAddr, bus.HdrNextAddr, bus.DataClearAddr, bus.DataNextAddr} !== 7'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ctrl: got %b, want 0000000", {bus.Busy, bus.Done, bus.TxLoad, bus.HdrClearAddr, bus.HdrNextAddr, bus.DataClearAddr, bus.DataNextAddr});
        end
        vectors++;
        if (bus.TxByte !== 8'h00 || bus.SequenceNumber !== 16'h0000) begin
            miscompares++;
            $display("FAIL rst_mid_data: got TxByte=%02h seq=%04h, want 00/0000", bus.TxByte, bus.SequenceNumber);
        end
        vectors++;
        if (dut.state !== IDLE) begin miscompares++; $display("FAIL rst_mid_state: got %0d, want IDLE", dut.state); end
        Reset = 1'b0;
        expQ.delete(); obsQ.delete();
        expSeq = 16'h0000;
        x0 = txCnt;
        push_msg(16'd12, expSeq);
        run_msg(16'd12, cl, fl, da);
        expSeq++;
        vectors++;
        if (txCnt - x0 != 12) begin miscompares++; $display("FAIL rst_mid_resend: got %0d bytes, want 12", txCnt - x0); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL rst_mid_byte: got %02h, want %02h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        vectors++;
        if (bus.SequenceNumber !== 16'h0001) begin miscompares++; $display("FAIL rst_mid_seq: got %04h, want 0001", bus.SequenceNumber); end
    endtask

    task automatic test_back_to_back();
        int x0, d0, started3;
        logic [7:0] e, o;
        Reset = 1'b1;
        tick(); tick();
        Reset = 1'b0;
        expQ.delete(); obsQ.delete();
        x0 = txCnt; d0 = doneCnt; started3 = 0;
        for (int m = 0; m < 3; m++) push_msg(16'd8, 16'(m));
        bus.MsgByteCount = 16'd8;
        bus.Send = 1'b1;
        for (int n = 0; n < 200 && (doneCnt - d0) < 3; n++) begin
            tick();
            if (started3 > 0) begin
                started3++;
                bus.Send = (started3 < 10) ? started3[0] : 1'b0;
            end else if (doneCnt - d0 == 2 && bus.Busy) begin
                started3 = 1;
            end
        end
        bus.Send = 1'b0;
        repeat (30) tick();
        vectors++;
        if (doneCnt - d0 != 3 || txCnt - x0 != 24) begin
            miscompares++;
            $display("FAIL b2b_count: got done=%0d tx=%0d, want 3/24", doneCnt - d0, txCnt - x0);
        end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL b2b_byte: got %02h, want %02h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        vectors++;
        if (bus.SequenceNumber !== 16'h0003) begin miscompares++; $display("FAIL b2b_seq: got %04h, want 0003", bus.SequenceNumber); end
        expSeq = 16'h0003;
    endtask

    task automatic test_seq_wrap();
        logic cl;
        int fl, da;
        logic [7:0] e, o;
        force dut.seqNum = 16'hFFFF;
        tick();
        release dut.seqNum;
        expSeq = 16'hFFFF;
        push_msg(16'd8, expSeq);
        run_msg(16'd8, cl, fl, da);
        vectors++;
        if (da == 0) begin miscompares++; $display("FAIL wrap_timeout: Done got 0, want 1 within 400 cycles"); end
        while (expQ.size() > 0 && obsQ.size() > 0) begin
            e = expQ.pop_front(); o = obsQ.pop_front(); vectors++;
            if (o !== e) begin miscompares++; $display("FAIL wrap_byte: got %02h, want %02h", o, e); end
        end
        expQ.delete(); obsQ.delete();
        vectors++;
        if (bus.SequenceNumber !== 16'h0000) begin miscompares++; $display("FAIL wrap_seq: got %04h, want 0000", bus.SequenceNumber); end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by %0t, want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.Send         = 1'b0;
        bus.MsgByteCount = 16'd8;
        bus.TxReady      = 1'b1;
        test_reset();
        test_header_only();
        test_data_stream();
        test_backpressure();
        test_reset_mid_message();
        test_back_to_back();
        test_seq_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
